// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS multiply/divide unit beside the ALU.
// Holds the architectural HI/LO registers, executes mult/multu/div/divu over
// a fixed number of cycles (Busy high meanwhile), and services mthi/mtlo/mfhi/mflo.
// Optional feature macro: MDU_DIVZERO_EN -- divide by zero completes in one
// cycle with HI=dividend, LO=all ones, and a DivZero flag while it is in flight.
module mult_div_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] MDUSrcA,
   input  logic [31:0] MDUSrcB,
   input  logic [3:0]  MDUOp,
   input  logic        Start,
   output logic        Busy,
`ifdef MDU_DIVZERO_EN
   output logic        DivZero,
`endif
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUResult
);

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } md_op_e;

   md_op_e      op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
`ifdef MDU_DIVZERO_EN
   logic        dz_q, dz_d;
`endif

   // Arithmetic on the latched operands; 64-bit signed math keeps
   // 0x8000_0000 / -1 well defined before truncation to 32 bits.
   logic signed [63:0] sa_w, sb_w, smul_w;
   logic        [63:0] ua_w, ub_w, umul_w;
   logic        [31:0] sdiv_q_w, sdiv_r_w, udiv_q_w, udiv_r_w;
   logic               b_zero_w;
   logic        [31:0] res_hi_w, res_lo_w;
   logic               res_we_w;
   logic               launch_w;

   assign sa_w     = {{32{a_q[31]}}, a_q};
   assign sb_w     = {{32{b_q[31]}}, b_q};
   assign ua_w     = {32'd0, a_q};
   assign ub_w     = {32'd0, b_q};
   assign smul_w   = sa_w * sb_w;
   assign umul_w   = ua_w * ub_w;
   assign b_zero_w = (b_q == 32'd0);
   assign sdiv_q_w = b_zero_w ? 32'd0 : 32'(sa_w / sb_w);
   assign sdiv_r_w = b_zero_w ? 32'd0 : 32'(sa_w % sb_w);
   assign udiv_q_w = b_zero_w ? 32'd0 : a_q / b_q;
   assign udiv_r_w = b_zero_w ? 32'd0 : a_q % b_q;

   assign launch_w = Start && ((MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                               (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU));

   // Select the HI/LO write-back value for the operation in flight.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      res_hi_w = hi_q;
      res_lo_w = lo_q;
      res_we_w = 1'b0;
      case (op_q)
         OP_MULT:  begin {res_hi_w, res_lo_w} = smul_w; res_we_w = 1'b1; end
         OP_MULTU: begin {res_hi_w, res_lo_w} = umul_w; res_we_w = 1'b1; end
         OP_DIV:   begin res_lo_w = sdiv_q_w; res_hi_w = sdiv_r_w; res_we_w = !b_zero_w; end
         OP_DIVU:  begin res_lo_w = udiv_q_w; res_hi_w = udiv_r_w; res_we_w = !b_zero_w; end
         default:  ;
      endcase
`ifdef MDU_DIVZERO_EN
      if (dz_q) begin
         res_hi_w = a_q;
         res_lo_w = 32'hffff_ffff;
         res_we_w = 1'b1;
      end
`endif
   end

   // Next-state: count down while busy, otherwise accept a launch or an mthi/mtlo.
   always_comb begin
      op_d   = op_q;
      a_d    = a_q;
      b_d    = b_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
`ifdef MDU_DIVZERO_EN
      dz_d   = dz_q;
`endif
      if (busy_q) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            busy_d = 1'b0;
`ifdef MDU_DIVZERO_EN
            dz_d   = 1'b0;
`endif
            if (res_we_w) begin
               hi_d = res_hi_w;
               lo_d = res_lo_w;
            end
         end
      end else if (launch_w) begin
         op_d   = md_op_e'(MDUOp);
         a_d    = MDUSrcA;
         b_d    = MDUSrcB;
         busy_d = 1'b1;
         cnt_d  = (MDUOp == OP_MULT || MDUOp == OP_MULTU) ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
`ifdef MDU_DIVZERO_EN
         if ((MDUOp == OP_DIV || MDUOp == OP_DIVU) && MDUSrcB == 32'd0) begin
            cnt_d = 4'd1;
            dz_d  = 1'b1;
         end
`endif
      end else if (MDUOp == OP_MTHI) begin
         hi_d = MDUSrcA;
      end else if (MDUOp == OP_MTLO) begin
         lo_d = MDUSrcA;
      end
   end

   // State registers; reset aborts any operation without touching HI/LO beyond clearing them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q   <= OP_NOP;
         a_q    <= '0;
         b_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
`ifdef MDU_DIVZERO_EN
         dz_q   <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         op_q   <= op_d;
         a_q    <= a_d;
         b_q    <= b_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
`ifdef MDU_DIVZERO_EN
         dz_q   <= dz_d;
`endif
      end
   end

   // mfhi/mflo read port; returns the stale value while an operation is in flight.
   always_comb begin
      MDUResult = 32'd0;
      if (MDUOp == OP_MFHI)      MDUResult = hi_q;
      else if (MDUOp == OP_MFLO) MDUResult = lo_q;
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;
`ifdef MDU_DIVZERO_EN
   assign DivZero = dz_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against a
// transaction-level model (result computed at launch, committed at a due cycle).
module tb_mult_div_unit;

   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a, b;
   logic [3:0]  op;
   logic        start;
   logic        busy;
   logic [31:0] hi, lo, res;
`ifdef MDU_DIVZERO_EN
   logic        divzero;
`endif

   always #5 clk = ~clk;

   mult_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .MDUSrcA   (a),
      .MDUSrcB   (b),
      .MDUOp     (op),
      .Start     (start),
      .Busy      (busy),
`ifdef MDU_DIVZERO_EN
      .DivZero   (divzero),
`endif
      .HI        (hi),
      .LO        (lo),
      .MDUResult (res)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of one md operation from plain 64-bit arithmetic.
   function automatic void model_result(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                        output logic [31:0] rh, output logic [31:0] rl, output bit we);
      longint          sx, sy;
      longint unsigned ux, uy;
      logic [63:0]     prod;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      rh = 32'd0;
      rl = 32'd0;
      we = 1'b0;
      case (o)
         4'd1: begin prod = sx * sy; rh = prod[63:32]; rl = prod[31:0]; we = 1'b1; end
         4'd2: begin prod = ux * uy; rh = prod[63:32]; rl = prod[31:0]; we = 1'b1; end
         4'd3: if (y != 0) begin rl = 32'(sx / sy); rh = 32'(sx % sy); we = 1'b1; end
         4'd4: if (y != 0) begin rl = 32'(ux / uy); rh = 32'(ux % uy); we = 1'b1; end
         default: ;
      endcase
`ifdef MDU_DIVZERO_EN
      if ((o == 4'd3 || o == 4'd4) && y == 0) begin
         rh = x;
         rl = 32'hffff_ffff;
         we = 1'b1;
      end
`endif
   endfunction

   // Model state: visible HI/LO, pending result and the cycle it is due.
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   bit          m_busy, m_dz, p_we;
   int          m_cyc, m_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hi = 0; m_lo = 0; m_busy = 0; m_dz = 0; p_we = 0; m_cyc = 0; m_done = 0;
      end else begin
         m_cyc++;
         if (m_busy) begin
            if (m_cyc == m_done) begin
               if (p_we) begin m_hi = p_hi; m_lo = p_lo; end
               m_busy = 0;
               m_dz   = 0;
            end
         end else if (start && op >= 4'd1 && op <= 4'd4) begin
            int n;
            model_result(op, a, b, p_hi, p_lo, p_we);
            n    = (op <= 4'd2) ? MUL_N : DIV_N;
            m_dz = 0;
`ifdef MDU_DIVZERO_EN
            if (op >= 4'd3 && b == 0) begin n = 1; m_dz = 1; end
`endif
            m_done = m_cyc + n;
            m_busy = 1;
         end else if (op == 4'd7) begin
            m_hi = a;
         end else if (op == 4'd8) begin
            m_lo = a;
         end
      end
   end

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [31:0] exp_res;
         exp_res = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
         check("busy", busy, m_busy);
         check("hi", hi, m_hi);
         check("lo", lo, m_lo);
         check("mduresult", res, exp_res);
`ifdef MDU_DIVZERO_EN
         check("divzero", divzero, m_busy && m_dz);
`endif
      end
   end

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic s);
      op = o; a = x; b = y; start = s;
   endtask

   task automatic idle();
      drive(4'd0, 32'd0, 32'd0, 1'b0);
   endtask

   // Count falling edges with Busy high until it drops; bounded.
   task automatic busy_len(output int n);
      n = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (!busy) return;
         n++;
      end
      n_tests++;
      n_fail++;
      $display("FAIL busy_timeout: Busy still high after %0d cycles, required to drop", n);
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hffff_ffff;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int n;
      idle();
      @(posedge clk);
      cmp_en = 1'b1;
      #2;
      check("rst_busy", busy, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      next();
      rst_n = 1'b1;
      next();

      // MULT -3 * 5
      drive(4'd1, 32'hffff_fffd, 32'd5, 1'b1); next(); idle();
      busy_len(n);
      check("mult_cycles", n, 5);
      check("mult_hi", hi, 32'hffff_ffff);
      check("mult_lo", lo, 32'hffff_fff1);

      // MULTU 0xffffffff * 2
      next();
      drive(4'd2, 32'hffff_ffff, 32'd2, 1'b1); next(); idle();
      busy_len(n);
      check("multu_cycles", n, 5);
      check("multu_hi", hi, 32'd1);
      check("multu_lo", lo, 32'hffff_fffe);

      // DIVU 100 / 7
      next();
      drive(4'd4, 32'd100, 32'd7, 1'b1); next(); idle();
      busy_len(n);
      check("divu_cycles", n, 10);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);

      // DIV -7 / 2 with an ignored MULT start two cycles in
      next();
      drive(4'd3, 32'hffff_fff9, 32'd2, 1'b1); next(); idle();
      next(); next();
      drive(4'd1, 32'd3, 32'd3, 1'b1); next(); idle();
      repeat (6) next();
      check("div_busy_c9", busy, 1);
      next();
      check("div_busy_c10", busy, 0);
      check("div_lo", lo, 32'hffff_fffd);
      check("div_hi", hi, 32'hffff_ffff);

      // Signed overflow edge case
      drive(4'd3, 32'h8000_0000, 32'hffff_ffff, 1'b1); next(); idle();
      busy_len(n);
      check("divovf_lo", lo, 32'h8000_0000);
      check("divovf_hi", hi, 32'd0);

      // MTLO then MFLO / MFHI / NOP reads
      next();
      drive(4'd8, 32'h1234_5678, 32'd0, 1'b0); next(); idle();
      check("mtlo_lo", lo, 32'h1234_5678);
      drive(4'd6, 32'd0, 32'd0, 1'b0); #1;
      check("mflo_res", res, 32'h1234_5678);
      drive(4'd5, 32'd0, 32'd0, 1'b0); #1;
      check("mfhi_res", res, 32'd0);
      idle(); #1;
      check("nop_res", res, 32'd0);

      // MTHI while busy is ignored; MFLO while busy reads the stale value
      next();
      drive(4'd1, 32'd2, 32'd3, 1'b1); next();
      drive(4'd7, 32'hdead_beef, 32'd0, 1'b0); next();
      check("mthi_busy_hi", hi, 32'd0);
      drive(4'd6, 32'd0, 32'd0, 1'b0); #1;
      check("mflo_stale", res, 32'h1234_5678);
      idle();
      busy_len(n);
      check("mul6_lo", lo, 32'd6);
      check("mul6_hi", hi, 32'd0);

      // Divide by zero
      next();
      drive(4'd7, 32'haaaa_5555, 32'd0, 1'b0); next();
      drive(4'd8, 32'h5555_aaaa, 32'd0, 1'b0); next();
      drive(4'd3, 32'd77, 32'd0, 1'b1); next(); idle();
      busy_len(n);
`ifdef MDU_DIVZERO_EN
      check("dz_cycles", n, 1);
      check("dz_hi", hi, 32'd77);
      check("dz_lo", lo, 32'hffff_ffff);
`else
      check("dz_cycles", n, 10);
      check("dz_hi", hi, 32'haaaa_5555);
      check("dz_lo", lo, 32'h5555_aaaa);
`endif

      // Asynchronous reset in the middle of a MULT
      next();
      drive(4'd1, 32'd7, 32'd9, 1'b1); next(); idle();
      next(); next();
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_hi", hi, 0);
      check("arst_lo", lo, 0);
      next(); next();
      rst_n = 1'b1;
      repeat (8) next();
      check("arst_late_busy", busy, 0);
      check("arst_late_hi", hi, 0);
      check("arst_late_lo", lo, 0);

      // Randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 1500; i++) begin
         logic [3:0] o;
         o = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
         drive(o, rand_opnd(), rand_opnd(), $urandom_range(0, 3) != 0);
         next();
      end
      idle();
      repeat (20) next();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
